vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen_if.sv | 34 +++
 rtl/vga_sync_gen.sv | 100 ++++++++++
 tb/tb_vga_sync_gen.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from the VGA sync generator to the pin mapping and renderer.
// The generator drives everything; consumers only observe.
interface vga_sync_gen_if;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       line_tick;
  logic       frame_tick;
  logic [7:0] frame_cnt;

  modport master (
    output hsync,
    output vsync,
    output display_on,
    output hpos,
    output vpos,
    output line_tick,
    output frame_tick,
    output frame_cnt
  );

  modport slave (
    input hsync,
    input vsync,
    input display_on,
    input hpos,
    input vpos,
    input line_tick,
    input frame_tick,
    input frame_cnt
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, registered syncs, blanking and
// per-line / per-frame strobes, all aligned to the registered hpos/vpos.
module vga_sync_gen #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FP             = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BP             = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FP             = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BP             = 33,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_sync_gen_if.master vga_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The counters are 10 bits wide, so larger rasters cannot be represented.
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_params
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic       SYNC_ON    = (SYNC_ACTIVE_HIGH != 0);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       line_tick_q, line_tick_d;
  logic       frame_tick_q, frame_tick_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Decodes use the next counter values so each flopped output lines up with
  // the hpos/vpos registered on the same edge.
  always_comb begin
    hpos_d = hpos_q + 10'd1;
    vpos_d = vpos_q;
    if (hpos_q == H_LAST) begin
      hpos_d = '0;
      if (vpos_q == V_LAST) begin
        vpos_d = '0;
      end else begin
        vpos_d = vpos_q + 10'd1;
      end
    end

    hsync_d      = ((hpos_d >= HS_FIRST) && (hpos_d <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
    vsync_d      = ((vpos_d >= VS_FIRST) && (vpos_d <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
    display_on_d = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    line_tick_d  = (hpos_d == '0);
    frame_tick_d = (hpos_d == '0) && (vpos_d == V_VIS);
    frame_cnt_d  = frame_cnt_q + 8'(frame_tick_d);
  end

  // Reset parks the raster on its last pixel so the first edge afterwards lands on (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpos_q       <= H_LAST;
      vpos_q       <= V_LAST;
      hsync_q      <= ~SYNC_ON;
      vsync_q      <= ~SYNC_ON;
      display_on_q <= 1'b0;
      line_tick_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      hpos_q       <= hpos_d;
      vpos_q       <= vpos_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      display_on_q <= display_on_d;
      line_tick_q  <= line_tick_d;
      frame_tick_q <= frame_tick_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign vga_o.hsync      = hsync_q;
  assign vga_o.vsync      = vsync_q;
  assign vga_o.display_on = display_on_q;
  assign vga_o.hpos       = hpos_q;
  assign vga_o.vpos       = vpos_q;
  assign vga_o.line_tick  = line_tick_q;
  assign vga_o.frame_tick = frame_tick_q;
  assign vga_o.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: one full-size 640x480 instance plus two tiny-raster
// instances (both sync polarities) so whole frames fit in a short run.
module tb_vga_sync_gen;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] hp;
    logic [9:0] vp;
    logic       lt;
    logic       ft;
    logic [7:0] fc;
  } outs_t;

  typedef struct {
    int    sel;
    int    n;
    outs_t exp;
  } vec_t;

  typedef struct {
    int    cfg;
    outs_t exp;
  } sb_item_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = -1;
  int   checks = 0;
  int   errors = 0;
  sb_item_t sbQ[$];

  vga_sync_gen_if vFull();
  vga_sync_gen_if vSmall();
  vga_sync_gen_if vHi();

  vga_sync_gen dutFull (.clk(clk), .rst_n(rst_n), .vga_o(vFull));

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE_HIGH(0)
  ) dutSmall (.clk(clk), .rst_n(rst_n), .vga_o(vSmall));

  vga_sync_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_ACTIVE_HIGH(1)
  ) dutHi (.clk(clk), .rst_n(rst_n), .vga_o(vHi));

  always #5 clk = ~clk;

  // Clocks elapsed since the last reset release; n = 0 is the first edge after release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  function automatic outs_t mk(logic hs, logic vs, logic de, int hp, int vp,
                               logic lt, logic ft, int fc);
    outs_t e;
    e.hs = hs; e.vs = vs; e.de = de;
    e.hp = 10'(hp); e.vp = 10'(vp);
    e.lt = lt; e.ft = ft; e.fc = 8'(fc);
    return e;
  endfunction

  // Reference raster derived purely from the clock count since release.
  function automatic outs_t expFor(int cfg, int n);
    int ha, hf, hsw, hb, va, vf, vsw, vb, ht, vt, h, v, fr;
    logic hi;
    outs_t e;
    if (cfg == 0) begin
      ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33; hi = 1'b0;
    end else begin
      ha = 4; hf = 1; hsw = 2; hb = 3; va = 4; vf = 1; vsw = 2; vb = 1; hi = (cfg == 2);
    end
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (n < 0) return mk(~hi, ~hi, 1'b0, ht - 1, vt - 1, 1'b0, 1'b0, 0);
    h  = n % ht;
    v  = (n / ht) % vt;
    fr = (n >= va * ht) ? ((n - va * ht) / (ht * vt) + 1) : 0;
    e.hs = ((h >= ha + hf) && (h < ha + hf + hsw)) ? hi : ~hi;
    e.vs = ((v >= va + vf) && (v < va + vf + vsw)) ? hi : ~hi;
    e.de = (h < ha) && (v < va);
    e.hp = 10'(h);
    e.vp = 10'(v);
    e.lt = (h == 0);
    e.ft = (h == 0) && (v == va);
    e.fc = 8'(fr % 256);
    return e;
  endfunction

  function automatic outs_t sampleDut(int cfg);
    outs_t a;
    if (cfg == 0)
      a = {vFull.hsync, vFull.vsync, vFull.display_on, vFull.hpos, vFull.vpos,
           vFull.line_tick, vFull.frame_tick, vFull.frame_cnt};
    else if (cfg == 1)
      a = {vSmall.hsync, vSmall.vsync, vSmall.display_on, vSmall.hpos, vSmall.vpos,
           vSmall.line_tick, vSmall.frame_tick, vSmall.frame_cnt};
    else
      a = {vHi.hsync, vHi.vsync, vHi.display_on, vHi.hpos, vHi.vpos,
           vHi.line_tick, vHi.frame_tick, vHi.frame_cnt};
    return a;
  endfunction

  function automatic string cfgName(int cfg);
    if (cfg == 0) return "full";
    if (cfg == 1) return "small";
    return "small_hi";
  endfunction

  task automatic applyStimulus(input logic rstVal);
    rst_n = rstVal;
  endtask

  task automatic checkOutput(input string name, input int n, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s n=%0d: got hs=%b vs=%b de=%b h=%0d v=%0d lt=%b ft=%b fc=%0d, want hs=%b vs=%b de=%b h=%0d v=%0d lt=%b ft=%b fc=%0d",
               name, n, act.hs, act.vs, act.de, act.hp, act.vp, act.lt, act.ft, act.fc,
               exp.hs, exp.vs, exp.de, exp.hp, exp.vp, exp.lt, exp.ft, exp.fc);
    end
  endtask

  task automatic waitForCycle(input int n);
    int budget = 0;
    while ((cyc < n) && (budget < 25000)) begin
      @(negedge clk);
      budget++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_cycle: reached n=%0d, wanted n=%0d", cyc, n);
    end
  endtask

  // Scoreboard: expectations queued just after each edge, compared on the falling edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 3; c++) sbQ.push_back('{c, expFor(c, cyc)});
    end
  end

  initial begin
    sb_item_t it;
    forever begin
      @(negedge clk);
      while (sbQ.size() > 0) begin
        it = sbQ.pop_front();
        checkOutput({"sb_", cfgName(it.cfg)}, cyc, sampleDut(it.cfg), it.exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    outs_t rstFull, rstSmall, rstHi;

    rstFull  = mk(1'b1, 1'b1, 1'b0, 799, 524, 1'b0, 1'b0, 0);
    rstSmall = mk(1'b1, 1'b1, 1'b0, 9, 7, 1'b0, 1'b0, 0);
    rstHi    = mk(1'b0, 1'b0, 1'b0, 9, 7, 1'b0, 1'b0, 0);

    //                  sel  n       hs    vs    de    h    v   lt    ft   fc
    vecs.push_back('{0, 0,   mk(1'b1, 1'b1, 1'b1, 0,   0, 1'b1, 1'b0, 0)});
    vecs.push_back('{2, 0,   mk(1'b0, 1'b0, 1'b1, 0,   0, 1'b1, 1'b0, 0)});
    vecs.push_back('{0, 1,   mk(1'b1, 1'b1, 1'b1, 1,   0, 1'b0, 1'b0, 0)});
    vecs.push_back('{1, 40,  mk(1'b1, 1'b1, 1'b0, 0,   4, 1'b1, 1'b1, 1)});
    vecs.push_back('{1, 41,  mk(1'b1, 1'b1, 1'b0, 1,   4, 1'b0, 1'b0, 1)});
    vecs.push_back('{2, 45,  mk(1'b1, 1'b0, 1'b0, 5,   4, 1'b0, 1'b0, 1)});
    vecs.push_back('{1, 49,  mk(1'b1, 1'b1, 1'b0, 9,   4, 1'b0, 1'b0, 1)});
    vecs.push_back('{1, 50,  mk(1'b1, 1'b0, 1'b0, 0,   5, 1'b1, 1'b0, 1)});
    vecs.push_back('{1, 55,  mk(1'b0, 1'b0, 1'b0, 5,   5, 1'b0, 1'b0, 1)});
    vecs.push_back('{2, 55,  mk(1'b1, 1'b1, 1'b0, 5,   5, 1'b0, 1'b0, 1)});
    vecs.push_back('{1, 69,  mk(1'b1, 1'b0, 1'b0, 9,   6, 1'b0, 1'b0, 1)});
    vecs.push_back('{1, 70,  mk(1'b1, 1'b1, 1'b0, 0,   7, 1'b1, 1'b0, 1)});
    vecs.push_back('{1, 79,  mk(1'b1, 1'b1, 1'b0, 9,   7, 1'b0, 1'b0, 1)});
    vecs.push_back('{1, 80,  mk(1'b1, 1'b1, 1'b1, 0,   0, 1'b1, 1'b0, 1)});
    vecs.push_back('{0, 639, mk(1'b1, 1'b1, 1'b1, 639, 0, 1'b0, 1'b0, 0)});
    vecs.push_back('{0, 640, mk(1'b1, 1'b1, 1'b0, 640, 0, 1'b0, 1'b0, 0)});
    vecs.push_back('{0, 655, mk(1'b1, 1'b1, 1'b0, 655, 0, 1'b0, 1'b0, 0)});
    vecs.push_back('{0, 656, mk(1'b0, 1'b1, 1'b0, 656, 0, 1'b0, 1'b0, 0)});
    vecs.push_back('{0, 751, mk(1'b0, 1'b1, 1'b0, 751, 0, 1'b0, 1'b0, 0)});
    vecs.push_back('{0, 752, mk(1'b1, 1'b1, 1'b0, 752, 0, 1'b0, 1'b0, 0)});
    vecs.push_back('{0, 799, mk(1'b1, 1'b1, 1'b0, 799, 0, 1'b0, 1'b0, 0)});
    vecs.push_back('{0, 800, mk(1'b1, 1'b1, 1'b1, 0,   1, 1'b1, 1'b0, 0)});
    vecs.push_back('{0, 801, mk(1'b1, 1'b1, 1'b1, 1,   1, 1'b0, 1'b0, 0)});

    $display("[TB] reset sequence");
    #1 applyStimulus(1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset_full",  cyc, sampleDut(0), rstFull);
    checkOutput("reset_small", cyc, sampleDut(1), rstSmall);
    checkOutput("reset_hi",    cyc, sampleDut(2), rstHi);
    repeat (3) @(negedge clk);
    #1 applyStimulus(1'b1);

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      waitForCycle(vecs[i].n);
      checkOutput($sformatf("vec%0d_%s", i, cfgName(vecs[i].sel)), cyc,
                  sampleDut(vecs[i].sel), vecs[i].exp);
    end

    $display("[TB] frame counter wrap");
    waitForCycle(20439);
    checkOutput("fc_255",  cyc, sampleDut(1), mk(1'b1, 1'b1, 1'b0, 9, 3, 1'b0, 1'b0, 255));
    waitForCycle(20440);
    checkOutput("fc_wrap", cyc, sampleDut(1), mk(1'b1, 1'b1, 1'b0, 0, 4, 1'b1, 1'b1, 0));
    waitForCycle(20520);
    checkOutput("fc_257",  cyc, sampleDut(1), mk(1'b1, 1'b1, 1'b0, 0, 4, 1'b1, 1'b1, 1));

    $display("[TB] asynchronous reset mid-frame");
    waitForCycle(20595);
    checkOutput("pre_rst_small", cyc, sampleDut(1), mk(1'b0, 1'b1, 1'b0, 5, 3, 1'b0, 1'b0, 1));
    #2 applyStimulus(1'b0);
    #1;
    checkOutput("async_rst_full",  cyc, sampleDut(0), rstFull);
    checkOutput("async_rst_small", cyc, sampleDut(1), rstSmall);
    checkOutput("async_rst_hi",    cyc, sampleDut(2), rstHi);
    repeat (2) @(negedge clk);
    #1 applyStimulus(1'b1);
    waitForCycle(0);
    checkOutput("restart_full",  cyc, sampleDut(0), mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 0));
    checkOutput("restart_small", cyc, sampleDut(1), mk(1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 0));
    checkOutput("restart_hi",    cyc, sampleDut(2), mk(1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 0));
    waitForCycle(1);
    checkOutput("restart1_small", cyc, sampleDut(1), mk(1'b1, 1'b1, 1'b1, 1, 0, 1'b0, 1'b0, 0));
    waitForCycle(45);
    checkOutput("restart45_hi",   cyc, sampleDut(2), mk(1'b1, 1'b0, 1'b0, 5, 4, 1'b0, 1'b0, 1));

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
